cpu_bus_router: RTL

Single-master bus router between the CPU load/store port and the SoC slaves: instruction memory, data memory and the ASCON accelerator. It consumes the one-hot selects that the address decoder produces combinationally from `cpu_addr`. It registers each request, drives exactly one slave request, waits for that slave's acknowledge and returns the read data or a bus error to the CPU. Invalid addresses and, optionally, hung slaves end in an error response; faults are logged in a saturating counter and a fault-address register.

---
 rtl/soc_bus_pkg.sv | 31 +++
 rtl/bus_timeout_ctr.sv | 28 ++
 rtl/cpu_bus_router.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared encodings and defaults for the CPU bus router
package soc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } bus_state_t;

    typedef enum logic [1:0] {
        TGT_IMEM  = 2'd0,
        TGT_DMEM  = 2'd1,
        TGT_ASCON = 2'd2
    } bus_target_t;

    localparam int TIMEOUT_CYCLES_DEFAULT = 255;
    localparam int TIMEOUT_CTR_W          = 16;

    // Selects are one-hot; priority only matters if the decoder misbehaves.
    function automatic bus_target_t encode_target(input logic sel_dmem, input logic sel_ascon);
        if (sel_ascon) begin
            return TGT_ASCON;
        end
        if (sel_dmem) begin
            return TGT_DMEM;
        end
        return TGT_IMEM;
    endfunction

endpackage

// File: rtl/bus_timeout_ctr.sv
// rtl/bus_timeout_ctr.sv - WAIT-cycle counter flagging the limit-th cycle without ack
module bus_timeout_ctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of already-elapsed ack-less cycles
    assign expired = enable && (count == limit - W'(1));

endmodule

// File: rtl/cpu_bus_router.sv
// rtl/cpu_bus_router.sv - CPU to IMEM/DMEM/ASCON router; optional BUS_TIMEOUT_EN aborts hung slaves
module cpu_bus_router
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    input  logic              sel_imem,
    input  logic              sel_dmem,
    input  logic              sel_ascon,
    input  logic              sel_invalid,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    output logic              m_we,
    output logic              imem_req,
    output logic              dmem_req,
    output logic              ascon_req,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    input  logic              ascon_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic [DATA_W-1:0] ascon_rdata,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] err_addr
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("cpu_bus_router: TIMEOUT_CYCLES must be at least 1");
    end

    bus_state_t        state;
    bus_state_t        state_nxt;
    bus_target_t       target;
    logic [DATA_W-1:0] rdata_q;
    logic              tgt_ack;
    logic [DATA_W-1:0] tgt_rdata;
    logic              sel_valid;
    logic              timeout;

    assign sel_valid = !sel_invalid && (sel_imem || sel_dmem || sel_ascon);

    always_comb begin
        tgt_ack   = 1'b0;
        tgt_rdata = '0;
        case (target)
            TGT_IMEM:  begin tgt_ack = imem_ack;  tgt_rdata = imem_rdata;  end
            TGT_DMEM:  begin tgt_ack = dmem_ack;  tgt_rdata = dmem_rdata;  end
            TGT_ASCON: begin tgt_ack = ascon_ack; tgt_rdata = ascon_rdata; end
            default:   ;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    bus_timeout_ctr #(
        .W(TIMEOUT_CTR_W)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != ST_WAIT),
        .enable  ((state == ST_WAIT) && !tgt_ack),
        .limit   (TIMEOUT_CTR_W'(TIMEOUT_CYCLES)),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cpu_req) begin
                    state_nxt = sel_valid ? ST_WAIT : ST_ERR;
                end
            end
            ST_WAIT: begin
                // a same-cycle ack beats the timeout
                if (tgt_ack) begin
                    state_nxt = ST_RESP;
                end else if (timeout) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            ST_ERR:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            target    <= TGT_IMEM;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_we      <= 1'b0;
            rdata_q   <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_WAIT) begin
                m_addr  <= cpu_addr;
                m_wdata <= cpu_wdata;
                m_wstrb <= cpu_wstrb;
                m_we    <= cpu_we;
                target  <= encode_target(sel_dmem, sel_ascon);
            end
            if (state == ST_WAIT && tgt_ack) begin
                rdata_q <= tgt_rdata;
            end
            if (state_nxt == ST_ERR) begin
                err_addr <= (state == ST_IDLE) ? cpu_addr : m_addr;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign cpu_ready = (state == ST_RESP) || (state == ST_ERR);
    assign cpu_err   = (state == ST_ERR);
    assign cpu_rdata = (state == ST_RESP) ? rdata_q : '0;
    assign imem_req  = (state == ST_WAIT) && (target == TGT_IMEM);
    assign dmem_req  = (state == ST_WAIT) && (target == TGT_DMEM);
    assign ascon_req = (state == ST_WAIT) && (target == TGT_ASCON);

endmodule
